leddisplay_rx: RTL



---
 rtl/leddisplay_pkg.sv | 31 +++
 rtl/leddisplay_rx_if.sv | 9 +
 rtl/leddisplay_rx_sync_edge.sv | 27 ++
 rtl/leddisplay_rx.sv | 101 ++++++++++
 4 files changed

// File: rtl/leddisplay_pkg.sv
// Shared frame layout for the 595-style LED display link.
// Used by both the display driver and the receiver.
package leddisplay_pkg;

  localparam int FRAME_W = 16;
  localparam int SEL_W   = 5;
  localparam int SEG_W   = 8;
  localparam logic [2:0] HDR_VAL = 3'b111;

  localparam int HDR_MSB = 15;
  localparam int HDR_LSB = 13;
  localparam int SEL_MSB = 12;
  localparam int SEL_LSB = 8;
  localparam int SEG_MSB = 7;
  localparam int SEG_LSB = 0;

  typedef struct packed {
    logic [2:0]       hdr;
    logic [SEL_W-1:0] sel;
    logic [SEG_W-1:0] seg;
  } frame_t;

  function automatic frame_t split_frame(input logic [FRAME_W-1:0] raw);
    frame_t f;
    f.hdr = raw[HDR_MSB:HDR_LSB];
    f.sel = raw[SEL_MSB:SEL_LSB];
    f.seg = raw[SEG_MSB:SEG_LSB];
    return f;
  endfunction

endpackage

// File: rtl/leddisplay_rx_if.sv
// Serial display link as emitted by the display driver (data, shift clock, latch clock).
interface leddisplay_rx_if;
  logic ser;
  logic sck;
  logic rck;

  modport master (output ser, sck, rck);
  modport slave  (input  ser, sck, rck);
endinterface

// File: rtl/leddisplay_rx_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/leddisplay_rx.sv
// Snoops the serial display link, emulates the 16-bit shift/storage registers
// and decodes each latched frame into per-digit segment bytes.
module leddisplay_rx
  import leddisplay_pkg::*;
#(
  parameter int          NUM     = 4,
  parameter bit          MODE    = 1'b0,
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input  logic             clk,
  input  logic             rstn,
  leddisplay_rx_if.slave   link,
  output logic [NUM*8-1:0] led_out,
  output logic [NUM-1:0]   digit_valid,
  output logic             upd_valid,
  output logic [SEL_W-1:0] upd_sel,
  output logic             frame_err,
  output logic             link_alive
);

  logic ser_lvl, ser_rise;
  logic sck_lvl, sck_rise;
  logic rck_lvl, rck_rise;

  sync_edge u_ser (.clk(clk), .rstn(rstn), .din(link.ser), .level(ser_lvl), .rise(ser_rise));
  sync_edge u_sck (.clk(clk), .rstn(rstn), .din(link.sck), .level(sck_lvl), .rise(sck_rise));
  sync_edge u_rck (.clk(clk), .rstn(rstn), .din(link.rck), .level(rck_lvl), .rise(rck_rise));

  // Only the rise of sck/rck and the level of ser carry information.
  logic unused_sync;
  assign unused_sync = ser_rise ^ sck_lvl ^ rck_lvl;

  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] frame;
  logic               pend;

  // A same-cycle latch sees the pre-shift contents, like a 595 with tied clocks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg <= '0;
      frame <= '0;
      pend  <= 1'b0;
    end else begin
      pend <= rck_rise;
      if (rck_rise) frame <= shreg;
      if (sck_rise) shreg <= {shreg[FRAME_W-2:0], ser_lvl};
    end
  end

  frame_t           fld;
  logic             frame_ok;
  logic [SEL_W-1:0] slot;

  always_comb begin
    fld      = split_frame(frame);
    frame_ok = (fld.hdr == HDR_VAL) && (32'(fld.sel) < 32'(NUM));
    slot     = MODE ? fld.sel : SEL_W'(NUM - 1) - fld.sel;
  end

  logic [31:0] to_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_out     <= '0;
      digit_valid <= '0;
      upd_valid   <= 1'b0;
      upd_sel     <= '0;
      frame_err   <= 1'b0;
      link_alive  <= 1'b0;
      to_cnt      <= '0;
    end else begin
      upd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (pend) begin
        if (frame_ok) begin
          for (int i = 0; i < NUM; i++) begin
            if (32'(slot) == 32'(i)) begin
              led_out[i*8 +: 8] <= fld.seg;
              digit_valid[i]    <= 1'b1;
            end
          end
          upd_sel   <= fld.sel;
          upd_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
      // Alive drops on the very edge where the idle count reaches TIMEOUT.
      if (pend && frame_ok) begin
        to_cnt     <= '0;
        link_alive <= 1'b1;
      end else if (to_cnt < TIMEOUT) begin
        to_cnt <= to_cnt + 32'd1;
        if (to_cnt == TIMEOUT - 32'd1) link_alive <= 1'b0;
      end else begin
        link_alive <= 1'b0;
      end
    end
  end

endmodule
